immu_responder: RTL
===================

IMMU_RESPONDER -- requirements
Module: immu_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 2, meaning cycles from request acceptance to response; legal range 1..15.
REQ-002 SHALL have parameter BASE_OFFSET, default 64'h0000_0000_8000_0000, meaning value added to vaddr to form paddr.
REQ-003 SHALL have parameter VADDR_LIMIT, default 64'h0000_0001_0000_0000, meaning first illegal fetch vaddr.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port fetch_req  input  1  I$ translation request valid.
REQ-007 SHALL have port fetch_vaddr  input  64  virtual fetch address.
REQ-008 SHALL have port cacheable  input  1  request attribute, echoed on response.
REQ-009 SHALL have port kill  input  1  I$ flush; cancels outstanding request.
REQ-010 SHALL have port req_ready  output  1  request accepted on edge where fetch_req & req_ready & !kill.
REQ-011 SHALL have port fetch_valid  output  1  translation response valid, one-cycle pulse.
REQ-012 SHALL have port fetch_paddr  output  64  translated physical address.
REQ-013 SHALL have port rsp_cacheable  output  1  echoed cacheable, 0 on exception.
REQ-014 SHALL have port ex_valid  output  1  response carries fetch exception.
REQ-015 SHALL have port ex_cause  output  4  4'd0 misaligned fetch, 4'd1 fetch access fault.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, RESP; req_ready = 1 only in IDLE.
REQ-017 SHALL on acceptance capture vaddr and cacheable, go to RESP if LATENCY==1, else WAIT with counter loaded LATENCY-1.
REQ-018 SHALL in WAIT decrement the counter each cycle and enter RESP on the edge where counter reaches 1 -> 0 transition completes (total WAIT residence LATENCY-1 cycles).
REQ-019 SHALL assert fetch_valid only in RESP, exactly one cycle, LATENCY cycles after the accepting edge; RESP -> IDLE unconditionally next edge.
REQ-020 SHALL not accept fetch_req in WAIT or RESP; requester must hold or reissue; no queuing.
REQ-021 SHALL compute fetch_paddr = captured vaddr + BASE_OFFSET, 64-bit, carry-out discarded (wrap).
REQ-022 SHALL flag misaligned (cause 0) when captured vaddr[1:0] != 0; this takes priority over access fault.
REQ-023 SHALL flag access fault (cause 1) when captured vaddr >= VADDR_LIMIT (unsigned) and aligned.
REQ-024 SHALL on exception drive ex_valid=1, fetch_paddr=0, rsp_cacheable=0; otherwise ex_valid=0, ex_cause=0.
REQ-025 SHALL hold fetch_paddr, rsp_cacheable, ex_valid, ex_cause at 0 whenever fetch_valid=0.
REQ-026 SHALL, when kill=1 in WAIT or RESP, force fetch_valid=0 combinationally that cycle and return to IDLE next edge.
REQ-027 SHALL, when kill=1 in IDLE, not accept fetch_req that cycle (kill priority over request).
REQ-028 SHALL accept a new request in the cycle after RESP (back-to-back spacing LATENCY+1 cycles).

Reset
REQ-029 SHALL on rst=1 at an edge enter IDLE, clear counter and captured fields, regardless of current state.
REQ-030 SHALL while rst=1 drive req_ready=0, fetch_valid=0, fetch_paddr=0, rsp_cacheable=0, ex_valid=0, ex_cause=0.
REQ-031 SHALL discard any in-flight request on reset mid-operation; no response after rst deasserts.
REQ-032 SHALL have rst priority over kill and fetch_req.

Verification
REQ-033 SHALL cover: LATENCY=2, accept vaddr 64'h1000 cacheable=1 at edge T -> fetch_valid only in cycle T+2, paddr 64'h8000_1000, rsp_cacheable=1, ex_valid=0; req_ready=1 again in cycle T+3.
REQ-034 SHALL cover: vaddr 64'h1002 -> ex_valid=1, ex_cause=0, paddr=0, rsp_cacheable=0.
REQ-035 SHALL cover: vaddr 64'h1_0000_0000 -> ex_cause=1; vaddr 64'hFFFF_FFFF_FFFF_FFF2 -> ex_cause=0 (priority).
REQ-036 SHALL cover: kill in cycle T+1 after accept -> no fetch_valid; req_ready=1 in cycle T+2; kill with fetch_req in IDLE -> no accept.
REQ-037 SHALL cover: rst asserted in WAIT -> all outputs 0 next cycle, no later fetch_valid; LATENCY=1 run -> fetch_valid in cycle T+1.
REQ-038 SHALL cover: fetch_req held high continuously with LATENCY=2 -> accepts every 3 cycles, one fetch_valid per accept.

Source files
------------

// File: rtl/immu_responder.sv
// Fixed-latency I$ translation responder: paddr = vaddr + BASE_OFFSET, LATENCY cycles after accept.
// One request in flight; req_ready is low until the response cycle has passed, and kill/rst cancel it.
module immu_responder #(
   parameter int unsigned LATENCY     = 2,
   parameter logic [63:0] BASE_OFFSET = 64'h0000_0000_8000_0000,
   parameter logic [63:0] VADDR_LIMIT = 64'h0000_0001_0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        fetch_req,
   input  logic [63:0] fetch_vaddr,
   input  logic        cacheable,
   input  logic        kill,
   output logic        req_ready,
   output logic        fetch_valid,
   output logic [63:0] fetch_paddr,
   output logic        rsp_cacheable,
   output logic        ex_valid,
   output logic [3:0]  ex_cause
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [63:0] vaddr_q;
   logic        cach_q;
   logic        accept;
   logic        misaligned;
   logic        access_fault;

   assign accept = (state_q == IDLE) && fetch_req && !kill;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         vaddr_q <= 64'd0;
         cach_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            vaddr_q <= fetch_vaddr;
            cach_q  <= cacheable;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (LATENCY == 1) begin
                  state_d = RESP;
               end else begin
                  state_d = WAIT;
                  cnt_d   = CNT_INIT;
               end
            end
         end
         WAIT: begin
            if (kill) begin
               state_d = IDLE;
               cnt_d   = 4'd0;
            end else begin
               cnt_d = cnt_q - 4'd1;
               if (cnt_q <= 4'd1) begin
                  state_d = RESP;
               end
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

   // Misalignment outranks the range check, so a misaligned high address reports cause 0.
   assign misaligned   = (vaddr_q[1:0] != 2'b00);
   assign access_fault = !misaligned && (vaddr_q >= VADDR_LIMIT);

   always_comb begin
      req_ready     = 1'b0;
      fetch_valid   = 1'b0;
      fetch_paddr   = 64'd0;
      rsp_cacheable = 1'b0;
      ex_valid      = 1'b0;
      ex_cause      = 4'd0;
      if (!rst) begin
         req_ready = (state_q == IDLE);
         if ((state_q == RESP) && !kill) begin
            fetch_valid = 1'b1;
            if (misaligned || access_fault) begin
               ex_valid = 1'b1;
               ex_cause = misaligned ? 4'd0 : 4'd1;
            end else begin
               fetch_paddr   = vaddr_q + BASE_OFFSET;
               rsp_cacheable = cach_q;
            end
         end
      end
   end

endmodule
